// File: rtl/sata_phy_pkg.sv
// Shared constants, FSM encodings and the K28.5 lane finder for the
// SATA primitive-alignment layer.
package sata_phy_pkg;

    localparam logic [31:0] ALIGN_DW = 32'h7B4A4ABC;
    localparam logic [3:0]  ALIGN_K  = 4'b0001;
    localparam logic [31:0] SYNC_DW  = 32'hB5B5957C;
    localparam logic [3:0]  SYNC_K   = 4'b0001;
    localparam logic [7:0]  K285     = 8'hBC;

    localparam logic [1:0] TX_ALIGN0 = 2'd0;
    localparam logic [1:0] TX_ALIGN1 = 2'd1;
    localparam logic [1:0] TX_DATA   = 2'd2;

    localparam logic [1:0] LINK_DOWN  = 2'd0;
    localparam logic [1:0] LINK_CHECK = 2'd1;
    localparam logic [1:0] LINK_UP    = 2'd2;

    // Returns {hit, lane}: lowest byte lane carrying a K28.5.
    function automatic logic [2:0] k285_detect(input logic [31:0] d, input logic [3:0] k);
        logic [2:0] r;
        r = 3'b000;
        for (int j = 3; j >= 0; j--)
            if (k[j] && d[j*8 +: 8] == K285)
                r = {1'b1, 2'(j)};
        return r;
    endfunction

endpackage

// File: rtl/sata_phy_align_ch.sv
// One channel: TX ALIGN-pair insertion plus RX realignment and link lock.
module sata_phy_align_ch
    import sata_phy_pkg::*;
#(
    parameter int C_ALIGN_INTERVAL = 254,
    parameter int C_LOCK_ALIGNS    = 4,
    parameter int C_LOSS_TIMEOUT   = 1024
) (
    input  logic        phyclk,
    input  logic        phyreset,
    input  logic [31:0] txdata,
    input  logic        txdatak,
    output logic        txdatak_pop,
    output logic [31:0] gtx_txdata,
    output logic [3:0]  gtx_txdatak,
    input  logic [31:0] gtx_rxdata,
    input  logic [3:0]  gtx_rxdatak,
    output logic [31:0] rxdata,
    output logic        rxdatak,
    output logic        rxvalid,
    output logic        link_up,
    output logic        rx_lost
);

    logic [1:0] tx_state;
    logic [9:0] tx_cnt;

    assign txdatak_pop = (tx_state == TX_DATA);

    always_ff @(posedge phyclk) begin
        if (phyreset) begin
            tx_state    <= TX_ALIGN0;
            tx_cnt      <= '0;
            gtx_txdata  <= ALIGN_DW;
            gtx_txdatak <= ALIGN_K;
        end else begin
            case (tx_state)
                TX_ALIGN0: begin
                    gtx_txdata  <= ALIGN_DW;
                    gtx_txdatak <= ALIGN_K;
                    tx_state    <= TX_ALIGN1;
                end
                TX_ALIGN1: begin
                    gtx_txdata  <= ALIGN_DW;
                    gtx_txdatak <= ALIGN_K;
                    tx_state    <= TX_DATA;
                end
                TX_DATA: begin
                    gtx_txdata  <= txdata;
                    gtx_txdatak <= {3'b000, txdatak};
                    if (tx_cnt == 10'(C_ALIGN_INTERVAL - 1)) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_ALIGN0;
                    end else begin
                        tx_cnt <= tx_cnt + 10'd1;
                    end
                end
                default: tx_state <= TX_ALIGN0;
            endcase
        end
    end

    logic [31:0] prev;
    logic [3:0]  prevk;
    logic [1:0]  shift;
    logic [3:0]  lock_cnt;
    logic [15:0] wd_cnt;
    logic [1:0]  lstate;
    logic [63:0] cat;
    logic [7:0]  catk;
    logic [31:0] aligned;
    logic        aligned_k;
    logic        is_align;
    logic [2:0]  det;
    logic        mismatch;

    // The dword starting at the K28.5 lane straddles the previous and current raw words.
    always_comb begin
        cat       = {gtx_rxdata, prev};
        catk      = {gtx_rxdatak, prevk};
        aligned   = 32'(cat >> {shift, 3'b000});
        aligned_k = catk[{1'b0, shift}];
        is_align  = (aligned == ALIGN_DW);
        det       = k285_detect(gtx_rxdata, gtx_rxdatak);
        mismatch  = det[2] && (det[1:0] != shift);
    end

    assign link_up = (lstate == LINK_UP);

    always_ff @(posedge phyclk) begin
        if (phyreset) begin
            prev     <= '0;
            prevk    <= '0;
            rxdata   <= '0;
            rxdatak  <= 1'b0;
            rxvalid  <= 1'b0;
            rx_lost  <= 1'b0;
            shift    <= '0;
            lock_cnt <= '0;
            wd_cnt   <= '0;
            lstate   <= LINK_DOWN;
        end else begin
            prev    <= gtx_rxdata;
            prevk   <= gtx_rxdatak;
            rxdata  <= aligned;
            rxdatak <= aligned_k;
            rxvalid <= (lstate == LINK_UP) && !is_align;
            rx_lost <= 1'b0;
            case (lstate)
                LINK_DOWN: begin
                    if (det[2]) begin
                        shift    <= det[1:0];
                        lock_cnt <= '0;
                        lstate   <= LINK_CHECK;
                    end
                end
                LINK_CHECK: begin
                    if (mismatch) begin
                        lstate <= LINK_DOWN;
                    end else if (is_align) begin
                        lock_cnt <= lock_cnt + 4'd1;
                        if (lock_cnt == 4'(C_LOCK_ALIGNS - 1)) begin
                            lstate <= LINK_UP;
                            wd_cnt <= '0;
                        end
                    end
                end
                LINK_UP: begin
                    // An ALIGN arriving on the expiry dword still rescues the link.
                    if (mismatch || (!is_align && wd_cnt == 16'(C_LOSS_TIMEOUT))) begin
                        lstate  <= LINK_DOWN;
                        rx_lost <= 1'b1;
                        wd_cnt  <= '0;
                    end else if (is_align) begin
                        wd_cnt <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                default: lstate <= LINK_DOWN;
            endcase
        end
    end

endmodule

// File: rtl/sata_phy_align.sv
// N-channel SATA alignment layer: one independent sata_phy_align_ch per channel.
module sata_phy_align
    import sata_phy_pkg::*;
#(
    parameter int C_NUM_CH         = 2,
    parameter int C_ALIGN_INTERVAL = 254,
    parameter int C_LOCK_ALIGNS    = 4,
    parameter int C_LOSS_TIMEOUT   = 1024
) (
    input  logic                    phyclk,
    input  logic                    phyreset,
    input  logic [C_NUM_CH*32-1:0]  txdata,
    input  logic [C_NUM_CH-1:0]     txdatak,
    output logic [C_NUM_CH-1:0]     txdatak_pop,
    output logic [C_NUM_CH*32-1:0]  gtx_txdata,
    output logic [C_NUM_CH*4-1:0]   gtx_txdatak,
    input  logic [C_NUM_CH*32-1:0]  gtx_rxdata,
    input  logic [C_NUM_CH*4-1:0]   gtx_rxdatak,
    output logic [C_NUM_CH*32-1:0]  rxdata,
    output logic [C_NUM_CH-1:0]     rxdatak,
    output logic [C_NUM_CH-1:0]     rxvalid,
    output logic [C_NUM_CH-1:0]     link_up,
    output logic [C_NUM_CH-1:0]     rx_lost
);

    for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
        sata_phy_align_ch #(
            .C_ALIGN_INTERVAL(C_ALIGN_INTERVAL),
            .C_LOCK_ALIGNS   (C_LOCK_ALIGNS),
            .C_LOSS_TIMEOUT  (C_LOSS_TIMEOUT)
        ) u_ch (
            .phyclk     (phyclk),
            .phyreset   (phyreset),
            .txdata     (txdata[i*32 +: 32]),
            .txdatak    (txdatak[i]),
            .txdatak_pop(txdatak_pop[i]),
            .gtx_txdata (gtx_txdata[i*32 +: 32]),
            .gtx_txdatak(gtx_txdatak[i*4 +: 4]),
            .gtx_rxdata (gtx_rxdata[i*32 +: 32]),
            .gtx_rxdatak(gtx_rxdatak[i*4 +: 4]),
            .rxdata     (rxdata[i*32 +: 32]),
            .rxdatak    (rxdatak[i]),
            .rxvalid    (rxvalid[i]),
            .link_up    (link_up[i]),
            .rx_lost    (rx_lost[i])
        );
    end

endmodule

// File: doc/sata_phy_align.md
# sata_phy_align

Parametrised N-channel SATA primitive-alignment layer sitting between the link-layer FIFOs (`txdata`/`rxdata`) and the transceiver wrappers (`gtx_txdata`/`gtx_rxdata`).

- **TX side:** inserts the mandatory ALIGN pair every `C_ALIGN_INTERVAL` dwords and back-pressures the source through `txdatak_pop`.
- **RX side:** restores dword alignment from the K28.5 lane, strips ALIGN primitives, and runs a per-channel link-lock state machine that drives `link_up`.
- Replaces the fixed two-channel interface glue. Channel count, insertion interval and lock thresholds are generics.

## Interface
Parameters:
- `C_NUM_CH`, 2: number of channels (1–8). Channel i uses slice `[i*32 +: 32]` of 32-bit buses, `[i*4 +: 4]` of 4-bit buses, and bit `[i]` of 1-bit buses.
- `C_ALIGN_INTERVAL`, 254: data dwords sent between ALIGN pairs (2–1023).
- `C_LOCK_ALIGNS`, 4: lane-consistent ALIGNs required to declare link up (1–15).
- `C_LOSS_TIMEOUT`, 1024: dwords without an ALIGN before link is declared lost (must be > `C_ALIGN_INTERVAL`+2, < 65536).

Ports:
- `phyclk` in 1: single clock for all logic.
- `phyreset` in 1: synchronous, active-high reset.
- `txdata` in 32·N: dword from link layer.
- `txdatak` in N: 1 = dword is a primitive (K on byte 0).
- `txdatak_pop` out N: accept strobe; `txdata`/`txdatak` consumed this cycle.
- `gtx_txdata` out 32·N: dword to transceiver.
- `gtx_txdatak` out 4·N: charisk to transceiver.
- `gtx_rxdata` in 32·N: raw dword from transceiver.
- `gtx_rxdatak` in 4·N: raw charisk.
- `rxdata` out 32·N: aligned dword to link layer.
- `rxdatak` out N: aligned dword is a primitive.
- `rxvalid` out N: `rxdata` valid (link up, not ALIGN).
- `link_up` out N: per-channel lock status.
- `rx_lost` out N: one-cycle pulse on LINK_UP→LINK_DOWN.

## Operation
Constants:
- ALIGN = 0x7B4A4ABC, charisk 4'b0001.
- K28.5 = byte 0xBC with its K bit set.

TX FSM (per channel), states TX_ALIGN0 → TX_ALIGN1 → TX_DATA:
- TX_ALIGN0 / TX_ALIGN1: drive ALIGN; `txdatak_pop`=0.
- TX_DATA: `txdatak_pop`=1 (combinational, from state). Register `txdata` to `gtx_txdata`; `gtx_txdatak` = {3'b0, `txdatak`}. Increment `tx_cnt` (10 bits).
- When `tx_cnt` = `C_ALIGN_INTERVAL`−1 in TX_DATA: go to TX_ALIGN0 and clear `tx_cnt`.
- TX is independent of `link_up`; OOB gating is done upstream.

RX datapath:
- Stage 1 registers raw dword/charisk as `prev`.
- Lane detect: lowest lane s with K28.5 in the raw input.
- Stage 2 output:
  - `rxdata` = ({cur,prev} >> 8·`shift`)[31:0]
  - `rxdatak` = ({curk,prevk} >> `shift`)[0]
- ALIGN is recognised on the aligned dword.

Link FSM (per channel):
- **LINK_DOWN:**
  - On detect: load `shift`=s, clear `lock_cnt`, go to LINK_CHECK.
- **LINK_CHECK:**
  - Aligned ALIGN: `lock_cnt`++; at `C_LOCK_ALIGNS` go to LINK_UP.
  - Detect on lane ≠ `shift`: go to LINK_DOWN.
- **LINK_UP:**
  - `link_up`=1.
  - `wd_cnt` (16 bits) increments per dword and clears on an aligned ALIGN.
  - Go to LINK_DOWN and pulse `rx_lost` when either:
    - `wd_cnt` = `C_LOSS_TIMEOUT`, or
    - a K28.5 is detected on a lane ≠ `shift`.
- `rxvalid` = LINK_UP & !(aligned dword == ALIGN).

Reset values (all outputs and state):
- `gtx_txdata`=ALIGN, `gtx_txdatak`=4'b0001, TX state TX_ALIGN0, `tx_cnt`=0.
- `rxdata`=0, `rxdatak`=0, `rxvalid`=0, `link_up`=0, `rx_lost`=0.
- `shift`=0, `lock_cnt`=0, `wd_cnt`=0, link state LINK_DOWN.

## Timing
Latencies:
- TX: `txdata` accepted in cycle t appears on `gtx_txdata` at t+1.
- RX: `gtx_rxdata` at cycle t contributes to `rxdata` at t+2.
- `link_up` rises in the cycle after the `C_LOCK_ALIGNS`-th ALIGN is seen on the aligned output.

TX sequence from reset release: ALIGN, ALIGN, then `C_ALIGN_INTERVAL` pops, repeating.

Boundary conditions:
- A mid-operation `phyreset` aborts every FSM in the next cycle, with no partial ALIGN pair.
- Simultaneous watchdog expiry and ALIGN arrival: the ALIGN wins (counter clears).
- Channels are fully independent.

## Structure
- **Shared package `sata_phy_pkg`:**
  - ALIGN/SYNC dword and charisk constants.
  - K28.5 byte.
  - TX and link FSM state encodings.
- **Sub-module `sata_phy_align_ch`:** one channel, instantiated `C_NUM_CH` times by a generate loop in the top.

## Test plan
- **Reset and TX cadence:** reset then `C_ALIGN_INTERVAL`=4, `txdata`=incrementing from 1 → `gtx_txdata` = ALIGN, ALIGN, 1, 2, 3, 4, ALIGN, ALIGN, 5… `txdatak_pop` low exactly during ALIGNs.
- **Lock with byte shift:** RX stream byte-shifted so K28.5 sits on lane 2, `C_LOCK_ALIGNS`=4 → `link_up` rises after the 4th ALIGN. `rxdata` shows data 0x11223344 unshifted, `rxvalid` low on ALIGNs.
- **Lane change during check:** K28.5 on lane 2 then lane 1 during LINK_CHECK → return to LINK_DOWN, `link_up` stays 0.
- **Watchdog loss:** locked link, ALIGNs stopped for `C_LOSS_TIMEOUT`=1024 dwords → `rx_lost` 1-cycle pulse, `link_up`=0.
- **Reset during lock, multi-channel:** `C_NUM_CH`=4, ch1 locked, ch3 fed garbage, `phyreset` mid-stream → all outputs return to reset values the next cycle. After release, ch1 relocks while ch3 stays down.
